// File: rtl/dmem_access_controller_pkg.sv
// Shared definitions for the MA-stage data-memory access controller.
// Holds the controller state encoding, the RV32 load/store func_3 codes,
// the access-size field codes and the datapath width constants.
package dmem_access_controller_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // func_3[1:0] selects the access size; any code other than these two
    // (including the unused 011/110/111 encodings) is handled as a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

endpackage

// File: rtl/ma_lane_align.sv
// Combinational byte-lane steering for MA-stage loads and stores.
// Ports:
//   func_3     in   access size (bits 1:0) and unsigned flag (bit 2)
//   offset     in   addr[1:0] of the access
//   wdata      in   raw store data (DATA_2)
//   rdata      in   word returned by data memory
//   be         out  byte enables for a store
//   store_word out  store data replicated across the selected lanes
//   load_word  out  loaded value shifted down and sign/zero extended
//   aligned    out  1 when offset is legal for the access size
module ma_lane_align
    import dmem_access_controller_pkg::*;
(
    input  logic [2:0]        func_3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] store_word,
    output logic [DATA_W-1:0] load_word,
    output logic              aligned
);

    logic [DATA_W-1:0] shifted;
    logic              is_unsigned;

    assign is_unsigned = func_3[2];

    always_comb begin
        // Bring the addressed byte/half down to bit 0.
        shifted    = rdata >> {offset, 3'b000};
        be         = '1;
        store_word = wdata;
        load_word  = shifted;
        aligned    = (offset == 2'b00);

        case (func_3[1:0])
            SZ_B: begin
                be         = 4'b0001 << offset;
                store_word = {4{wdata[7:0]}};
                load_word  = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
                aligned    = 1'b1;
            end
            SZ_H: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata[15:0]}};
                load_word  = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
                aligned    = ~offset[0];
            end
            default: begin
                be         = 4'b1111;
                store_word = wdata;
                load_word  = shifted;
                aligned    = (offset == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_controller.sv
// MA-stage data-memory access controller for the RV32IM pipeline.
// Turns the EX/MA memory-control fields into a req/ack transaction on a
// multi-cycle data memory, stalls the pipeline while the access is
// outstanding, formats load/store lanes and flags misaligned accesses and
// ack timeouts.
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   mem_read, mem_write       load / store request from EX/MA
//   func_3, addr, wdata       access size/sign, byte address, store data
//   stall                     holds PC and upstream pipeline registers
//   load_data, load_valid     extended load result and its one-cycle strobe
//   dmem_req, dmem_we         memory request and write flag
//   dmem_addr, dmem_wdata     word address and lane-replicated store data
//   dmem_be                   byte enables
//   dmem_rdata, dmem_ack      memory read word and completion
//   misaligned, timeout       fault pulses
module dmem_access_controller
    import dmem_access_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func_3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              misaligned,
    output logic              timeout
);

    localparam int              CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(MEM_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t            state;
    logic [2:0]        f3_p1;
    logic [1:0]        off_p1;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic              in_idle;
    logic              in_busy;
    logic              access;
    logic              start;
    logic [2:0]        la_f3;
    logic [1:0]        la_off;
    logic [BE_W-1:0]   la_be;
    logic [DATA_W-1:0] la_store;
    logic [DATA_W-1:0] la_load;
    logic              la_aligned;

    assign in_idle  = (state == ST_IDLE);
    assign in_busy  = (state == ST_BUSY);
    assign access   = mem_read | mem_write;
    assign start    = in_idle & access & la_aligned;
    assign cnt_next = sat_inc(cnt);

    // One lane aligner serves both directions: live EX/MA fields while idle
    // (store lanes, alignment), captured fields while busy (load extraction).
    assign la_f3  = in_idle ? func_3    : f3_p1;
    assign la_off = in_idle ? addr[1:0] : off_p1;

    ma_lane_align u_lane (
        .func_3     (la_f3),
        .offset     (la_off),
        .wdata      (wdata),
        .rdata      (dmem_rdata),
        .be         (la_be),
        .store_word (la_store),
        .load_word  (la_load),
        .aligned    (la_aligned)
    );

    // Gated by RESET_N so an asserted reset releases the pipeline at once,
    // even while EX/MA still presents an access.
    assign stall      = RESET_N & (start | in_busy);
    assign misaligned = RESET_N & in_idle & access & ~la_aligned;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            f3_p1      <= '0;
            off_p1     <= '0;
            cnt        <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                // Capture stage: latch the request fields from EX/MA.
                ST_IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        dmem_be    <= la_be;
                        dmem_wdata <= la_store;
                        f3_p1      <= func_3;
                        off_p1     <= addr[1:0];
                        cnt        <= '0;
                        state      <= ST_BUSY;
                    end
                end
                // Memory stage: hold the request until ack or timeout;
                // an ack in the limit cycle still completes normally.
                ST_BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= la_load;
                            load_valid <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else if (TIMEOUT_EN && (cnt_next == TO_LIMIT)) begin
                        dmem_req  <= 1'b0;
                        timeout   <= 1'b1;
                        load_data <= '0;
                        cnt       <= cnt_next;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                // Release stage: pipeline advances; inputs are ignored.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
